// File: rtl/pwm_pkg.sv
// Shared constants for the PWM generator: register map, CTRL bit positions and
// counter direction encoding.
package pwm_pkg;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned CTRL_W = 2;

  localparam logic [ADDR_W-1:0] ADDR_PERIOD = 4'd0;
  localparam logic [ADDR_W-1:0] ADDR_CTRL   = 4'd1;
  localparam logic [ADDR_W-1:0] ADDR_DT     = 4'd2;
  localparam logic [ADDR_W-1:0] ADDR_DUTY0  = 4'd3;

  localparam int unsigned CTRL_CENTER = 0;
  localparam int unsigned CTRL_INV    = 1;

  localparam logic [0:0] DIR_UP = 1'b0;
  localparam logic [0:0] DIR_DN = 1'b1;

endpackage

// File: rtl/pwm_deadtime.sv
// Per-channel dead-time insertion: an edge of raw only reaches its output once
// raw has held the new level for dt further cycles.
module pwm_deadtime #(
  parameter int unsigned DT_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_raw,
  input  logic [DT_W-1:0] i_dt,
  output logic            o_h_c,
  output logic            o_l_c
);

  logic            r_prev;
  logic [DT_W-1:0] r_age;
  logic            w_same;

  assign w_same = (i_raw == r_prev);

  // r_age counts earlier cycles at the current level, saturating.
  always_comb begin
    o_h_c = 1'b0;
    o_l_c = 1'b0;
    if (w_same) begin
      o_h_c = i_raw & (r_age >= i_dt);
      o_l_c = ~i_raw & (r_age >= i_dt);
    end else if (i_dt == '0) begin
      o_h_c = i_raw;
      o_l_c = ~i_raw;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev <= 1'b0;
      r_age  <= '0;
    end else begin
      r_prev <= i_raw;
      if (!w_same) begin
        r_age <= DT_W'(1);
      end else if (r_age != '1) begin
        r_age <= r_age + DT_W'(1);
      end
    end
  end

endmodule

// File: rtl/pwm_multi_gen.sv
// N-channel PWM generator: shared edge/center counter, shadowed config loaded at
// the period boundary, per-channel dead time and output polarity.
module pwm_multi_gen
  import pwm_pkg::*;
#(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned DT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [CNT_W-1:0]  cfg_wdata,
  output logic [N_CH-1:0]   pwm_h,
  output logic [N_CH-1:0]   pwm_l,
  output logic              sync_pulse,
  output logic              upd_pending
);

  localparam logic [ADDR_W:0] ADDR_END = (ADDR_W+1)'(int'(ADDR_DUTY0) + int'(N_CH));

  logic [CNT_W-1:0]  r_per_s, r_per_a;
  logic [CTRL_W-1:0] r_ctrl_s, r_ctrl_a;
  logic [DT_W-1:0]   r_dt_s, r_dt_a;
  logic [CNT_W-1:0]  r_duty_s [N_CH];
  logic [CNT_W-1:0]  r_duty_a [N_CH];
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [0:0]        r_dir, w_dir_nxt;
  logic              w_load, w_wr_valid, w_center, w_inv;
  logic [N_CH-1:0]   w_raw, w_h, w_l;

  assign w_wr_valid = cfg_we && ({1'b0, cfg_addr} < ADDR_END);
  assign w_center   = r_ctrl_a[CTRL_CENTER];
  assign w_inv      = r_ctrl_a[CTRL_INV];

  // Shadow bank: written by the config port at any time.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_per_s  <= '1;
      r_ctrl_s <= '0;
      r_dt_s   <= '0;
      for (int ch = 0; ch < int'(N_CH); ch++) r_duty_s[ch] <= '0;
    end else if (cfg_we) begin
      if (cfg_addr == ADDR_PERIOD) r_per_s  <= cfg_wdata;
      if (cfg_addr == ADDR_CTRL)   r_ctrl_s <= cfg_wdata[CTRL_W-1:0];
      if (cfg_addr == ADDR_DT)     r_dt_s   <= cfg_wdata[DT_W-1:0];
      for (int ch = 0; ch < int'(N_CH); ch++) begin
        if (cfg_addr == ADDR_DUTY0 + ADDR_W'(ch)) r_duty_s[ch] <= cfg_wdata;
      end
    end
  end

  // Active bank: follows shadow while idle, otherwise only at a load event.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_per_a  <= '1;
      r_ctrl_a <= '0;
      r_dt_a   <= '0;
      for (int ch = 0; ch < int'(N_CH); ch++) r_duty_a[ch] <= '0;
    end else if (!en || w_load) begin
      r_per_a  <= r_per_s;
      r_ctrl_a <= r_ctrl_s;
      r_dt_a   <= r_dt_s;
      r_duty_a <= r_duty_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_dir <= DIR_UP;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_dir <= w_dir_nxt;
    end
  end

  // Counter sequencing; w_load marks the last cycle of each period.
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_dir_nxt = r_dir;
    w_load    = 1'b0;
    if (!en) begin
      w_cnt_nxt = '0;
      w_dir_nxt = DIR_UP;
    end else if (r_per_a == '0) begin
      w_cnt_nxt = '0;
      w_dir_nxt = DIR_UP;
      w_load    = 1'b1;
    end else if (!w_center) begin
      w_dir_nxt = DIR_UP;
      if (r_cnt >= r_per_a) begin
        w_cnt_nxt = '0;
        w_load    = 1'b1;
      end else begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
      end
    end else begin
      case (r_dir)
        DIR_UP: begin
          if (r_cnt < r_per_a) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end else if (r_per_a == CNT_W'(1)) begin
            w_cnt_nxt = '0;
            w_load    = 1'b1;
          end else begin
            w_cnt_nxt = r_per_a - CNT_W'(1);
            w_dir_nxt = DIR_DN;
          end
        end
        DIR_DN: begin
          if (r_cnt <= CNT_W'(1)) begin
            w_cnt_nxt = '0;
            w_dir_nxt = DIR_UP;
            w_load    = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end
        end
      endcase
    end
  end

  for (genvar g = 0; g < int'(N_CH); g++) begin : g_ch
    assign w_raw[g] = en & (r_cnt < r_duty_a[g]);

    pwm_deadtime #(.DT_W(DT_W)) u_dt (
      .clk   (clk),
      .rst   (rst),
      .i_raw (w_raw[g]),
      .i_dt  (r_dt_a),
      .o_h_c (w_h[g]),
      .o_l_c (w_l[g])
    );
  end

  // Write beats load on the same cycle so the fresh shadow value stays flagged.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_h       <= '0;
      pwm_l       <= '0;
      sync_pulse  <= 1'b0;
      upd_pending <= 1'b0;
    end else begin
      pwm_h      <= (en ? w_h : '0) ^ {N_CH{w_inv}};
      pwm_l      <= (en ? w_l : '0) ^ {N_CH{w_inv}};
      sync_pulse <= w_load;
      if (!en) begin
        upd_pending <= 1'b0;
      end else if (w_wr_valid) begin
        upd_pending <= 1'b1;
      end else if (w_load) begin
        upd_pending <= 1'b0;
      end
    end
  end

endmodule
